// File: rtl/ysyx_2022040010_axi_rw.sv
// AXI4 master bridge: turns one flat rw request from the cache/uncache arbiter into one
// AXI4 read or write transaction. Optional macro AXI_RW_AW_W_PARALLEL_EN overlaps AW and W.
module ysyx_2022040010_axi_rw #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rw_valid_i,
    input  logic                    rw_req_i,
    input  logic [63:0]             rw_addr_i,
    input  logic [1:0]              rw_size_i,
    input  logic [3:0]              rw_id_i,
    input  logic [2*AXI_DATA_W-1:0] data_write_i,
    input  logic [7:0]              w_mask_i,
    output logic                    rw_ready_o,
    output logic [1:0]              rw_r_w_o,
    output logic [2*AXI_DATA_W-1:0] data_read_o,
    output logic [3:0]              rw_id_o,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_ADDR_W-1:0]   awaddr,
    output logic [AXI_ID_W-1:0]     awid,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [7:0]              wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    input  logic [AXI_ID_W-1:0]     bid,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [AXI_ADDR_W-1:0]   araddr,
    output logic [AXI_ID_W-1:0]     arid,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic [AXI_ID_W-1:0]     rid
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t                  state_r;
    logic [AXI_ADDR_W-1:0]   addr_r;
    logic [7:0]              len_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;
    logic [3:0]              id_r;
    logic [2*AXI_DATA_W-1:0] data_r;
    logic [AXI_DATA_W-1:0]   rlo_r;
    logic                    r_beat_r;
    logic [AXI_ADDR_W-1:0]   addr_s;
    logic                    unused_s;

    assign addr_s   = rw_addr_i[AXI_ADDR_W-1:0];
    assign unused_s = ^{rw_addr_i[63:AXI_ADDR_W], rresp, bresp, rid, bid};

    // Both address channels share one captured payload; only the active channel's valid rises.
    assign araddr  = addr_r;
    assign awaddr  = addr_r;
    assign arlen   = len_r;
    assign awlen   = len_r;
    assign arsize  = size_r;
    assign awsize  = size_r;
    assign arburst = burst_r;
    assign awburst = burst_r;
    assign arid    = AXI_ID_W'(id_r);
    assign awid    = AXI_ID_W'(id_r);

    // Request FSM with all AXI valid/ready and completion outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            addr_r      <= {AXI_ADDR_W{1'b0}};
            len_r       <= 8'd0;
            size_r      <= 3'd0;
            burst_r     <= 2'b00;
            id_r        <= 4'd0;
            data_r      <= {(2*AXI_DATA_W){1'b0}};
            rlo_r       <= {AXI_DATA_W{1'b0}};
            r_beat_r    <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            wdata       <= {AXI_DATA_W{1'b0}};
            wstrb       <= 8'd0;
            wlast       <= 1'b0;
            bready      <= 1'b0;
            rw_ready_o  <= 1'b0;
            rw_r_w_o    <= 2'b00;
            data_read_o <= {(2*AXI_DATA_W){1'b0}};
            rw_id_o     <= 4'd0;
        end else begin
            rw_ready_o <= 1'b0;
            rw_r_w_o   <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (rw_valid_i) begin
                        id_r     <= rw_id_i;
                        data_r   <= data_write_i;
                        wstrb    <= w_mask_i;
                        burst_r  <= 2'b01;
                        r_beat_r <= 1'b0;
                        // Uncache beats keep the exact address; cache lines align to 16 bytes.
                        if (rw_id_i[2]) begin
                            addr_r <= addr_s;
                            len_r  <= 8'd0;
                            size_r <= {1'b0, rw_size_i};
                        end else begin
                            addr_r <= {addr_s[AXI_ADDR_W-1:4], 4'h0};
                            len_r  <= 8'd1;
                            size_r <= 3'b011;
                        end
                        if (rw_req_i) begin
                            awvalid <= 1'b1;
                            state_r <= AW;
`ifdef AXI_RW_AW_W_PARALLEL_EN
                            wvalid  <= 1'b1;
                            wdata   <= data_write_i[AXI_DATA_W-1:0];
                            wlast   <= rw_id_i[2];
`endif
                        end else begin
                            arvalid <= 1'b1;
                            state_r <= AR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rlo_r    <= rdata;
                        r_beat_r <= 1'b1;
                        // rlast on the first beat leaves the upper half zero, even for a burst.
                        if (rlast) begin
                            rready      <= 1'b0;
                            rw_ready_o  <= 1'b1;
                            rw_r_w_o    <= 2'b01;
                            rw_id_o     <= id_r;
                            data_read_o <= r_beat_r ? {rdata, rlo_r} : {{AXI_DATA_W{1'b0}}, rdata};
                            state_r     <= DONE;
                        end
                    end
                end
                AW: begin
`ifdef AXI_RW_AW_W_PARALLEL_EN
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                        end else begin
                            wdata <= data_r[2*AXI_DATA_W-1:AXI_DATA_W];
                            wlast <= 1'b1;
                        end
                    end
                    // A channel whose valid is already low has finished its handshake.
                    if ((!awvalid || awready) && (!wvalid || (wready && wlast))) begin
                        bready  <= 1'b1;
                        state_r <= B;
                    end
`else
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= data_r[AXI_DATA_W-1:0];
                        wlast   <= (len_r == 8'd0);
                        state_r <= W;
                    end
`endif
                end
                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            bready  <= 1'b1;
                            state_r <= B;
                        end else begin
                            wdata <= data_r[2*AXI_DATA_W-1:AXI_DATA_W];
                            wlast <= 1'b1;
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        rw_ready_o <= 1'b1;
                        rw_r_w_o   <= 2'b10;
                        rw_id_o    <= id_r;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    wlast   <= 1'b0;
                    bready  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
